// File: rtl/branch_perf_monitor.sv
// branch_perf_monitor
//   Performance-event monitor fed by the CPU's flush, branch-resolve and retire
//   strobes. It keeps four counters: cycles, retired instructions, resolved
//   branches and misprediction events. Each counter has a sticky overflow flag.
//   A counter is read with a one-cycle request/ack handshake.
//
//   Optional build macro: PERF_SATURATE_EN
//     defined   - a counter holds at all-ones; its overflow flag sets on the
//                 first increment attempted at all-ones.
//     undefined - a counter wraps to zero; its overflow flag sets on the wrap.
module branch_perf_monitor #(
    parameter int unsigned CNT_W     = 32,
    parameter bit          CLR_START = 1'b1
) (
    input  logic             clk,
    input  logic             rst_BF_n,
    input  logic             start_i,
    input  logic             halt_i,
    input  logic             clear_i,
    input  logic             retire_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic             rd_req_i,
    input  logic [1:0]       rd_sel_i,
    output logic             rd_ack_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic [3:0]       ovf_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    // Counter slots; the index matches rd_sel_i and the ovf_o bit position
    localparam int unsigned IDX_CYC = 0;
    localparam int unsigned IDX_RET = 1;
    localparam int unsigned IDX_BR  = 2;
    localparam int unsigned IDX_MIS = 3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                  state_q, state_d;
    logic [3:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]              ovf_q, ovf_d;
    logic [3:0]              inc;
    logic                    flush_q;
    logic                    flush_rise;
    logic                    count_en;
    logic                    start_taken;
    logic                    zero_all;

    // Control state register
    always_ff @(posedge clk or negedge rst_BF_n) begin
        if (!rst_BF_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start leaves IDLE/FROZEN, halt only acts in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_i) begin
                    state_d = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counting is enabled for every RUN cycle, including the one where halt is taken
    assign count_en    = (state_q == ST_RUN);
    assign start_taken = start_i && (state_q != ST_RUN);
    assign zero_all    = clear_i || (CLR_START && start_taken);

    // A held flush is one misprediction; the previous level is tracked in all states
    assign flush_rise  = flush_i & ~flush_q;

    assign inc[IDX_CYC] = count_en;
    assign inc[IDX_RET] = count_en & retire_i;
    assign inc[IDX_BR]  = count_en & branch_i;
    assign inc[IDX_MIS] = count_en & flush_rise;

    // Previous flush level for edge detection
    always_ff @(posedge clk or negedge rst_BF_n) begin
        if (!rst_BF_n) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= flush_i;
        end
    end

    // Counter and overflow update; zeroing wins over any increment in the same cycle
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (zero_all) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (inc[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
`ifdef PERF_SATURATE_EN
                    cnt_d[i] = CNT_MAX;
`else
                    cnt_d[i] = '0;
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Counter and overflow registers
    always_ff @(posedge clk or negedge rst_BF_n) begin
        if (!rst_BF_n) begin
            cnt_q <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Read port: returns the value held before this edge's update, ack one cycle later
    always_ff @(posedge clk or negedge rst_BF_n) begin
        if (!rst_BF_n) begin
            rd_ack_o  <= 1'b0;
            rd_data_o <= '0;
        end else begin
            rd_ack_o <= rd_req_i;
            if (rd_req_i) begin
                rd_data_o <= cnt_q[rd_sel_i];
            end
        end
    end

    assign ovf_o   = ovf_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_branch_perf_monitor.sv
// tb_branch_perf_monitor
//   Directed bench for branch_perf_monitor: a 32-bit instance for the main
//   behaviour and a 4-bit instance (same stimulus) for counter overflow.
//   Honours PERF_SATURATE_EN for the overflow expectations.
module tb_branch_perf_monitor;

    logic        clk;
    logic        rst_BF_n;
    logic        start_i, halt_i, clear_i, retire_i, branch_i, flush_i, rd_req_i;
    logic [1:0]  rd_sel_i;

    logic        d_ack;
    logic [31:0] d_data;
    logic [3:0]  d_ovf;
    logic [1:0]  d_state;

    logic        s_ack;
    logic [3:0]  s_data;
    logic [3:0]  s_ovf;
    logic [1:0]  s_state;

    int total = 0;
    int bad   = 0;

    branch_perf_monitor #(.CNT_W(32), .CLR_START(1'b1)) dut (
        .clk(clk), .rst_BF_n(rst_BF_n), .start_i(start_i), .halt_i(halt_i),
        .clear_i(clear_i), .retire_i(retire_i), .branch_i(branch_i), .flush_i(flush_i),
        .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i), .rd_ack_o(d_ack), .rd_data_o(d_data),
        .ovf_o(d_ovf), .state_o(d_state)
    );

    branch_perf_monitor #(.CNT_W(4), .CLR_START(1'b1)) dut_small (
        .clk(clk), .rst_BF_n(rst_BF_n), .start_i(start_i), .halt_i(halt_i),
        .clear_i(clear_i), .retire_i(retire_i), .branch_i(branch_i), .flush_i(flush_i),
        .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i), .rd_ack_o(s_ack), .rd_data_o(s_data),
        .ovf_o(s_ovf), .state_o(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        start;
        bit        halt;
        bit        clear;
        bit        retire;
        bit        branch;
        bit        flush;
        bit        rd_req;
        bit [1:0]  sel;
        bit [1:0]  exp_state;
        bit        exp_ack;
        bit        chk_data;
        bit [31:0] exp_data;
    } vec_t;

    vec_t vec[19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start_i  = 1'b0; halt_i   = 1'b0; clear_i  = 1'b0; retire_i = 1'b0;
        branch_i = 1'b0; flush_i  = 1'b0; rd_req_i = 1'b0; rd_sel_i = 2'd0;
    endtask

    task automatic read_cnt(input logic [1:0] sel, input string name, output logic [31:0] data);
        rd_req_i = 1'b1;
        rd_sel_i = sel;
        tick();
        rd_req_i = 1'b0;
        check({name, "_ack"}, {63'd0, d_ack}, 64'd1);
        data = d_data;
    endtask

    task automatic pulse(input int len, input int gap);
        flush_i = 1'b1;
        repeat (len) tick();
        flush_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic single(input bit st, input bit ht);
        start_i = st;
        halt_i  = ht;
        tick();
        start_i = 1'b0;
        halt_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_small;

        // vector table: starts in FROZEN
        vec[0]  = '{start:1, halt:0, clear:0, retire:0, branch:0, flush:0, rd_req:0, sel:0, exp_state:1, exp_ack:0, chk_data:0, exp_data:0};
        for (int i = 1; i <= 7; i++)
            vec[i] = '{start:0, halt:0, clear:0, retire:0, branch:1, flush:0, rd_req:0, sel:0, exp_state:1, exp_ack:0, chk_data:0, exp_data:0};
        vec[8]  = '{start:0, halt:0, clear:0, retire:0, branch:1, flush:0, rd_req:1, sel:2, exp_state:1, exp_ack:1, chk_data:1, exp_data:7};
        vec[9]  = '{start:0, halt:0, clear:0, retire:0, branch:0, flush:0, rd_req:1, sel:2, exp_state:1, exp_ack:1, chk_data:1, exp_data:8};
        vec[10] = '{start:0, halt:0, clear:0, retire:0, branch:0, flush:0, rd_req:0, sel:0, exp_state:1, exp_ack:0, chk_data:1, exp_data:8};
        vec[11] = '{start:0, halt:1, clear:0, retire:1, branch:0, flush:0, rd_req:0, sel:0, exp_state:2, exp_ack:0, chk_data:1, exp_data:8};
        vec[12] = '{start:0, halt:0, clear:0, retire:0, branch:0, flush:0, rd_req:1, sel:1, exp_state:2, exp_ack:1, chk_data:1, exp_data:1};
        vec[13] = '{start:0, halt:0, clear:0, retire:0, branch:0, flush:0, rd_req:1, sel:0, exp_state:2, exp_ack:1, chk_data:1, exp_data:11};
        vec[14] = '{start:1, halt:0, clear:0, retire:0, branch:0, flush:0, rd_req:1, sel:2, exp_state:1, exp_ack:1, chk_data:1, exp_data:8};
        vec[15] = '{start:0, halt:0, clear:0, retire:0, branch:0, flush:0, rd_req:1, sel:2, exp_state:1, exp_ack:1, chk_data:1, exp_data:0};
        vec[16] = '{start:1, halt:1, clear:0, retire:0, branch:0, flush:0, rd_req:1, sel:0, exp_state:2, exp_ack:1, chk_data:1, exp_data:1};
        vec[17] = '{start:0, halt:1, clear:0, retire:0, branch:0, flush:0, rd_req:1, sel:0, exp_state:2, exp_ack:1, chk_data:1, exp_data:2};
        vec[18] = '{start:0, halt:0, clear:0, retire:0, branch:0, flush:0, rd_req:1, sel:3, exp_state:2, exp_ack:1, chk_data:1, exp_data:0};

        quiet();
        rst_BF_n = 1'b0;

        // 1: reset, run 10 cycles, halt, hold
        repeat (3) tick();
        check("rst_state", {62'd0, d_state}, 64'd0);
        check("rst_ack",   {63'd0, d_ack},   64'd0);
        check("rst_data",  {32'd0, d_data},  64'd0);
        check("rst_ovf",   {60'd0, d_ovf},   64'd0);
        rst_BF_n = 1'b1;
        single(1'b1, 1'b0);
        check("start_state", {62'd0, d_state}, 64'd1);
        repeat (10) tick();
        single(1'b0, 1'b1);
        check("halt_state", {62'd0, d_state}, 64'd2);
        repeat (20) tick();
        read_cnt(2'd0, "t1_cyc", rd);
        check("t1_cycles", {32'd0, rd}, 64'd11);
        read_cnt(2'd1, "t1_ret", rd);
        check("t1_retired", {32'd0, rd}, 64'd0);
        check("t1_frozen", {62'd0, d_state}, 64'd2);

        // 2: flush edge counting
        single(1'b1, 1'b0);
        pulse(1, 2); pulse(3, 2); pulse(1, 2);
        single(1'b0, 1'b1);
        read_cnt(2'd3, "t2a", rd);
        check("t2_mis_gap2", {32'd0, rd}, 64'd3);
        single(1'b1, 1'b0);
        pulse(1, 1); pulse(3, 1); pulse(1, 1);
        single(1'b0, 1'b1);
        read_cnt(2'd3, "t2b", rd);
        check("t2_mis_gap1", {32'd0, rd}, 64'd3);
        flush_i = 1'b1;
        single(1'b1, 1'b0);
        repeat (2) tick();
        flush_i = 1'b0;
        tick();
        single(1'b0, 1'b1);
        read_cnt(2'd3, "t2c", rd);
        check("t2_mis_preflush", {32'd0, rd}, 64'd0);

        // 3: clear beats retire in the same cycle
        single(1'b1, 1'b0);
        retire_i = 1'b1;
        repeat (5) tick();
        clear_i  = 1'b1;
        rd_req_i = 1'b1;
        rd_sel_i = 2'd1;
        tick();
        quiet();
        check("t3_ack",    {63'd0, d_ack},  64'd1);
        check("t3_before", {32'd0, d_data}, 64'd5);
        check("t3_state",  {62'd0, d_state}, 64'd1);
        check("t3_ovf",    {60'd0, d_ovf},  64'd0);
        read_cnt(2'd1, "t3_after", rd);
        check("t3_retired", {32'd0, rd}, 64'd0);
        single(1'b0, 1'b1);

        // 4: table-driven read/count sequence
        for (int i = 0; i < 19; i++) begin
            start_i  = vec[i].start;
            halt_i   = vec[i].halt;
            clear_i  = vec[i].clear;
            retire_i = vec[i].retire;
            branch_i = vec[i].branch;
            flush_i  = vec[i].flush;
            rd_req_i = vec[i].rd_req;
            rd_sel_i = vec[i].sel;
            tick();
            check($sformatf("vec%0d_state", i), {62'd0, d_state}, {62'd0, vec[i].exp_state});
            check($sformatf("vec%0d_ack", i),   {63'd0, d_ack},   {63'd0, vec[i].exp_ack});
            if (vec[i].chk_data)
                check($sformatf("vec%0d_data", i), {32'd0, d_data}, {32'd0, vec[i].exp_data});
        end
        quiet();

        // 5: 17 retires into a 4-bit counter
`ifdef PERF_SATURATE_EN
        exp_small = 32'd15;
`else
        exp_small = 32'd1;
`endif
        single(1'b1, 1'b0);
        retire_i = 1'b1;
        repeat (16) tick();
        single(1'b0, 1'b1);
        retire_i = 1'b0;
        read_cnt(2'd1, "t5", rd);
        check("t5_big_retired",   {32'd0, rd}, 64'd17);
        check("t5_small_retired", {60'd0, s_data}, {32'd0, exp_small});
        check("t5_small_ovf1",    {63'd0, s_ovf[1]}, 64'd1);
        check("t5_small_ovf2",    {63'd0, s_ovf[2]}, 64'd0);
        check("t5_big_ovf",       {60'd0, d_ovf}, 64'd0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("t5_clr_ovf",   {60'd0, s_ovf},   64'd0);
        check("t5_clr_state", {62'd0, s_state}, 64'd2);

        // 6: asynchronous reset with a read pending
        single(1'b1, 1'b0);
        retire_i = 1'b1;
        repeat (3) tick();
        read_cnt(2'd1, "t6_pre", rd);
        check("t6_pre_data", {32'd0, rd}, 64'd3);
        rd_req_i = 1'b1;
        #3;
        rst_BF_n = 1'b0;
        #1;
        check("t6_state", {62'd0, d_state}, 64'd0);
        check("t6_ack",   {63'd0, d_ack},   64'd0);
        check("t6_data",  {32'd0, d_data},  64'd0);
        check("t6_ovf",   {60'd0, d_ovf},   64'd0);
        check("t6_s_ovf", {60'd0, s_ovf},   64'd0);
        tick();
        check("t6_ack_in_rst", {63'd0, d_ack}, 64'd0);
        quiet();
        rst_BF_n = 1'b1;
        tick();
        check("t6_ack_after", {63'd0, d_ack},   64'd0);
        check("t6_idle",      {62'd0, d_state}, 64'd0);
        tick();
        check("t6_ack_after2", {63'd0, d_ack}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
